// File: rtl/sync_nff_gray_if.sv
// sync_nff_gray_if: pointer bundle between a gray source and its
// destination-domain synchroniser, plus the checker status/clear.
interface sync_nff_gray_if #(
  parameter int ASIZE = 4,
  parameter int NCH   = 1
);
  logic [NCH*ASIZE-1:0] src_ptr;
  logic [NCH*ASIZE-1:0] dest_ptr;
  logic [NCH*ASIZE-1:0] dest_bin;
  logic [NCH-1:0]       dest_chg;
  logic                 dest_vld;
  logic                 err_clr;
  logic [NCH-1:0]       err_flag;
  logic [7:0]           err_cnt;

  modport master (
    output src_ptr, err_clr,
    input  dest_ptr, dest_bin, dest_chg,
    input  dest_vld, err_flag, err_cnt
  );

  modport slave (
    input  src_ptr, err_clr,
    output dest_ptr, dest_bin, dest_chg,
    output dest_vld, err_flag, err_cnt
  );
endinterface

// File: rtl/sync_nff_gray.sv
// sync_nff_gray: NCH-channel STAGES-deep gray pointer synchroniser.
// Define SYNC_GRAY_CHECK_EN to build the single-bit-step checker.
module sync_nff_gray #(
  parameter int ASIZE  = 4,
  parameter int STAGES = 2,
  parameter int NCH    = 1
) (
  input logic           dest_clk,
  input logic           dest_rst,
  sync_nff_gray_if.slave bus
);
  localparam int W = NCH * ASIZE;
  localparam logic [2:0] PRIME_MAX = 3'(STAGES + 1);

  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("sync_nff_gray: STAGES must be 2..4");
  end

  logic [W-1:0]   sync_q [STAGES];
  logic [W-1:0]   dest_q;
  logic [W-1:0]   bin_d;
  logic [W-1:0]   bin_q;
  logic [NCH-1:0] chg_d;
  logic [NCH-1:0] chg_q;
  logic [2:0]     prime_q;
  logic           vld;
  logic           acc;

  assign vld = (prime_q == PRIME_MAX);

  // metastability chain; the last stage is the synchronised pointer
  always_ff @(posedge dest_clk or posedge dest_rst) begin
    if (dest_rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.src_ptr;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // gray->binary by running xor from msb, and per-channel change detect
  always_comb begin
    bin_d = '0;
    chg_d = '0;
    acc   = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      acc = 1'b0;
      for (int i = ASIZE - 1; i >= 0; i--) begin
        acc = acc ^ sync_q[STAGES-1][k*ASIZE+i];
        bin_d[k*ASIZE+i] = acc;
      end
      chg_d[k] = vld &&
        (sync_q[STAGES-1][k*ASIZE +: ASIZE] != dest_q[k*ASIZE +: ASIZE]);
    end
  end

  // post-stage registers: previous pointer, binary value, change pulse
  always_ff @(posedge dest_clk or posedge dest_rst) begin
    if (dest_rst) begin
      dest_q <= '0;
      bin_q  <= '0;
      chg_q  <= '0;
    end else begin
      dest_q <= sync_q[STAGES-1];
      bin_q  <= bin_d;
      chg_q  <= chg_d;
    end
  end

  // prime counter: saturates once the whole pipeline holds real samples
  always_ff @(posedge dest_clk or posedge dest_rst) begin
    if (dest_rst) begin
      prime_q <= '0;
    end else if (prime_q != PRIME_MAX) begin
      prime_q <= prime_q + 3'd1;
    end
  end

  assign bus.dest_ptr = sync_q[STAGES-1];
  assign bus.dest_bin = bin_q;
  assign bus.dest_chg = chg_q;
  assign bus.dest_vld = vld;

`ifdef SYNC_GRAY_CHECK_EN
  logic [NCH-1:0]   viol;
  logic [ASIZE-1:0] diff;
  logic [NCH-1:0]   flag_q;
  logic [7:0]       cnt_q;

  // more than one bit flipped between consecutive samples is a violation
  always_comb begin
    viol = '0;
    diff = '0;
    for (int k = 0; k < NCH; k++) begin
      diff = sync_q[STAGES-1][k*ASIZE +: ASIZE] ^ dest_q[k*ASIZE +: ASIZE];
      viol[k] = vld && (|(diff & (diff - ASIZE'(1))));
    end
  end

  // sticky flags and saturating counter; a fresh violation beats clear
  always_ff @(posedge dest_clk or posedge dest_rst) begin
    if (dest_rst) begin
      flag_q <= '0;
      cnt_q  <= '0;
    end else begin
      flag_q <= viol | (bus.err_clr ? '0 : flag_q);
      if (|viol) begin
        if (bus.err_clr)          cnt_q <= 8'd1;
        else if (cnt_q != 8'hff)  cnt_q <= cnt_q + 8'd1;
      end else if (bus.err_clr) begin
        cnt_q <= '0;
      end
    end
  end

  assign bus.err_flag = flag_q;
  assign bus.err_cnt  = cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.err_flag   = '0;
  assign bus.err_cnt    = '0;
`endif
endmodule

// File: tb/tb_sync_nff_gray.sv
// tb_sync_nff_gray: random and directed checks of sync_nff_gray
// against a sample-history model of the destination pipeline.
module tb_sync_nff_gray;
  localparam int A = 4;
  localparam int S = 3;
  localparam int N = 2;
  localparam int W = N * A;

  logic dest_clk = 1'b0;
  logic dest_rst;

  sync_nff_gray_if #(.ASIZE(A), .NCH(N)) bus ();

  sync_nff_gray #(.ASIZE(A), .STAGES(S), .NCH(N)) dut (
    .dest_clk(dest_clk),
    .dest_rst(dest_rst),
    .bus     (bus)
  );

  always #5 dest_clk = ~dest_clk;

  int n_checks = 0;
  int n_err    = 0;
  int c0, c1;
  logic [N-1:0] chg_or;

  // model: every src sample taken since reset release, one per edge
  logic [W-1:0] src_q[$];
  logic [N-1:0] m_flag;
  int           m_cnt;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] dp(input int m);
    if (m < S) return '0;
    return src_q[m-S];
  endfunction

  function automatic logic [A-1:0] chn(input logic [W-1:0] v, input int k);
    return v[k*A +: A];
  endfunction

  function automatic logic [A-1:0] g2b(input logic [A-1:0] g);
    logic [A-1:0] b;
    b = '0;
    for (int i = 0; i < A; i++) b = b ^ (g >> i);
    return b;
  endfunction

  function automatic int ones(input logic [A-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < A; i++) c += int'(v[i]);
    return c;
  endfunction

  task automatic model_edge();
    int n;
    logic [N-1:0] viol;
    if (dest_rst) return;
    n = src_q.size() + 1;
    viol = '0;
    for (int k = 0; k < N; k++)
      viol[k] = (n - 1 >= S + 1) &&
                (ones(chn(dp(n-1), k) ^ chn(dp(n-2), k)) > 1);
`ifdef SYNC_GRAY_CHECK_EN
    m_flag = viol | (bus.err_clr ? '0 : m_flag);
    if (|viol) m_cnt = bus.err_clr ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
    else if (bus.err_clr) m_cnt = 0;
`endif
    src_q.push_back(bus.src_ptr);
  endtask

  task automatic check_all();
    int n;
    logic [W-1:0] e_bin;
    logic [N-1:0] e_chg;
    n = src_q.size();
    e_bin = '0;
    e_chg = '0;
    for (int k = 0; k < N; k++) begin
      e_bin[k*A +: A] = g2b(chn(dp(n-1), k));
      e_chg[k] = (n - 1 >= S + 1) && (chn(dp(n-1), k) != chn(dp(n-2), k));
    end
    chk("ptr", 32'(bus.dest_ptr), 32'(dp(n)));
    chk("bin", 32'(bus.dest_bin), 32'(e_bin));
    chk("chg", 32'(bus.dest_chg), 32'(e_chg));
    chk("vld", 32'(bus.dest_vld), 32'(n >= S + 1));
    chk("flag", 32'(bus.err_flag), 32'(m_flag));
    chk("cnt", 32'(bus.err_cnt), 32'(m_cnt));
    c0 += int'(bus.dest_chg[0]);
    c1 += int'(bus.dest_chg[1]);
    chg_or |= bus.dest_chg;
  endtask

  task automatic step(input logic [W-1:0] s, input logic c);
    bus.src_ptr = s;
    bus.err_clr = c;
    @(posedge dest_clk);
    model_edge();
    @(negedge dest_clk);
    check_all();
  endtask

  task automatic do_reset(input logic [W-1:0] s);
    bus.src_ptr = s;
    bus.err_clr = 1'b0;
    dest_rst = 1'b1;
    #1;
    src_q.delete();
    m_flag = '0;
    m_cnt = 0;
    check_all();
    chk("rst_ptr", 32'(bus.dest_ptr), 32'd0);
    chk("rst_vld", 32'(bus.dest_vld), 32'd0);
    @(negedge dest_clk);
    check_all();
    @(negedge dest_clk);
    dest_rst = 1'b0;
    c0 = 0;
    c1 = 0;
    chg_or = '0;
  endtask

  initial begin
    int lat_ptr, lat_chg, vld_at;
    logic [A-1:0] b0, b1, g;
    dest_rst = 1'b1;
    bus.src_ptr = '0;
    bus.err_clr = 1'b0;
    m_flag = '0;
    m_cnt = 0;
    #2;
    do_reset('0);

    // latency of pointer and binary/change outputs
    repeat (10) step('0, 1'b0);
    lat_ptr = 0;
    lat_chg = 0;
    for (int i = 1; i <= 10; i++) begin
      step(8'h01, 1'b0);
      if (lat_ptr == 0 && bus.dest_ptr[3:0] == 4'b0001) lat_ptr = i;
      if (lat_chg == 0 && bus.dest_chg[0]) lat_chg = i;
    end
    chk("lat_ptr", 32'(lat_ptr), 32'(S));
    chk("lat_chg", 32'(lat_chg), 32'(S + 1));
    chk("lat_bin", 32'(bus.dest_bin[3:0]), 32'd1);

    // full gray sweep with wrap
    do_reset('0);
    repeat (S + 2) step('0, 1'b0);
    for (int v = 1; v <= 16; v++) begin
      g = A'(v % 16);
      g = g ^ (g >> 1);
      repeat (4) step({4'b0000, g}, 1'b0);
    end
    repeat (S + 2) step('0, 1'b0);
    chk("sweep_chg", 32'(c0), 32'd16);
    chk("sweep_flag", 32'(bus.err_flag), 32'd0);

    // reset priming with nonzero source held through reset
    do_reset({4'b0110, 4'b0110});
    vld_at = 0;
    for (int i = 1; i <= S + 4; i++) begin
      step({4'b0110, 4'b0110}, 1'b0);
      if (vld_at == 0 && bus.dest_vld) vld_at = i;
    end
    chk("prime_vld", 32'(vld_at), 32'(S + 1));
    chk("prime_chg", 32'(c0 + c1), 32'd0);
    chk("prime_bin", 32'(bus.dest_bin[3:0]), 32'b0100);

    // channel independence
    do_reset({4'b0011, 4'b0101});
    repeat (S + 2) step({4'b0011, 4'b0101}, 1'b0);
    chg_or = '0;
    repeat (S + 3) step({4'b0010, 4'b0101}, 1'b0);
    chk("mc_chg", 32'(chg_or), 32'b10);
    chk("mc_ptr0", 32'(bus.dest_ptr[3:0]), 32'b0101);
    chk("mc_bin0", 32'(bus.dest_bin[3:0]), 32'b0110);
    chk("mc_bin1", 32'(bus.dest_bin[7:4]), 32'b0011);

`ifdef SYNC_GRAY_CHECK_EN
    // checker: first violation, saturation, clear collision
    do_reset('0);
    repeat (S + 2) step('0, 1'b0);
    repeat (S + 2) step(8'h03, 1'b0);
    chk("viol_flag", 32'(bus.err_flag), 32'b01);
    chk("viol_cnt", 32'(bus.err_cnt), 32'd1);
    for (int i = 0; i < 300; i++) step((i % 2 == 0) ? 8'h00 : 8'h03, 1'b0);
    repeat (S + 2) step(8'h03, 1'b0);
    chk("sat_cnt", 32'(bus.err_cnt), 32'd255);
    repeat (S) step(8'h00, 1'b0);
    step(8'h00, 1'b1);
    chk("coll_flag", 32'(bus.err_flag), 32'b01);
    chk("coll_cnt", 32'(bus.err_cnt), 32'd1);
    step(8'h00, 1'b1);
    chk("clr_flag", 32'(bus.err_flag), 32'd0);
    chk("clr_cnt", 32'(bus.err_cnt), 32'd0);
`endif

    // asynchronous reset in the middle of a sweep
    do_reset('0);
    repeat (S + 2) step('0, 1'b0);
    for (int v = 1; v <= 6; v++) begin
      g = A'(v);
      g = g ^ (g >> 1);
      repeat (2) step({g, g}, 1'b0);
    end
    chk("pre_rst_ptr", 32'(bus.dest_ptr != '0), 32'd1);
    #2;
    do_reset('0);

    // randomized traffic with occasional illegal jumps and clears
    b0 = '0;
    b1 = '0;
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r >= 90) b0 = A'($urandom);
      else if (r >= 50) b0 = b0 + 1'b1;
      r = int'($urandom_range(0, 99));
      if (r >= 90) b1 = A'($urandom);
      else if (r >= 50) b1 = b1 + 1'b1;
      step({b1 ^ (b1 >> 1), b0 ^ (b0 >> 1)}, $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/sync_nff_gray.md
Name: sync_nff_gray

Overview:
Parametrised multi-channel N-stage synchroniser for gray-coded FIFO pointers. Lives entirely in the destination clock domain. Each channel's gray input is resynchronised, converted to binary, and marked with a change pulse. An optional checker flags samples that break the single-bit-step gray rule. It is the next generation of the existing 2-flop pointer synchroniser, used by the async FIFO read and write sides and by multi-queue loaders.

Parameters:
ASIZE, 4, pointer width per channel in bits (>=2)
STAGES, 2, synchroniser depth in flops (legal 2..4; other values are an elaboration error)
NCH, 1, number of independent pointer channels (>=1)

Ports:
dest_clk  input  1  destination clock; all flops on rising edge
dest_rst  input  1  asynchronous reset, active-high
src_ptr  input  NCH*ASIZE  gray pointers from the source domain; channel k is at [k*ASIZE +: ASIZE]
dest_ptr  output  NCH*ASIZE  synchronised gray pointers
dest_bin  output  NCH*ASIZE  registered binary equivalent of dest_ptr
dest_chg  output  NCH  1-cycle pulse per channel when the synchronised value changed
dest_vld  output  1  high once the pipeline is primed after reset
err_clr  input  1  clears error state (checker builds only; ignored otherwise)
err_flag  output  NCH  sticky per-channel gray-violation flag
err_cnt  output  8  saturating count of violation cycles

Behaviour:
- Reset (dest_rst=1, asynchronous): all sync stages = 0, dest_ptr = 0, dest_bin = 0, dest_chg = 0, dest_vld = 0, err_flag = 0, err_cnt = 0. Reset asserted mid-operation clears everything immediately. There is no partial state.
- Sync chain: each channel has STAGES flops in series; first flop samples src_ptr. dest_ptr is the last stage, so its latency is STAGES cycles.
- Post-stage register dest_q holds the previous dest_ptr, with latency STAGES+1.
- dest_bin is registered from dest_ptr, with latency STAGES+1:
  - b[ASIZE-1] = g[ASIZE-1]
  - b[i] = b[i+1] XOR g[i]
- dest_chg[k] = 1 for the cycle in which dest_ptr[k] != dest_q[k] is registered. It is aligned with dest_bin, so dest_bin and dest_chg update on the same edge.
- Prime counter:
  - 3-bit counter, 0 after reset, increments each cycle until it reaches STAGES+1, then holds.
  - dest_vld = 1 when the counter equals STAGES+1. It stays 1 until the next reset.
  - dest_chg is forced to 0 while dest_vld = 0, so no spurious pulse appears after reset release with a nonzero src_ptr.
- Channels are fully independent. Wrap-around (e.g. gray 1000 -> 0000 for ASIZE=4) is a legal single-bit step and produces dest_chg with no error.
- Without the checker build: err_flag = 0 and err_cnt = 0 constantly, and err_clr is unused.

Optional Feature:
Macro SYNC_GRAY_CHECK_EN.
- Defined:
  - Per channel, a violation is popcount(dest_ptr[k] XOR dest_q[k]) > 1, evaluated only when dest_vld = 1.
  - A violation sets err_flag[k] on the next edge. err_flag[k] stays set until err_clr.
  - err_cnt increments by 1 per cycle in which any channel violates, regardless of how many channels violate, and saturates at 255.
  - err_clr = 1 clears err_flag and err_cnt on the next edge.
  - If err_clr and a violation occur in the same cycle, the violation wins: the flag is set and err_cnt = 1.
- Not defined: checker logic is absent; outputs are tied as stated in Behaviour.

Test Plan:
- Latency: ASIZE=4, STAGES=3, NCH=1, src_ptr 0000 -> 0001 at cycle 10 -> dest_ptr=0001 at cycle 13; dest_bin=0001 and dest_chg=1 for one cycle at cycle 14.
- Gray sweep: drive gray counter 0..15 and wrap to 0, one step every 4 cycles -> dest_bin follows binary 0..15,0; 16 dest_chg pulses; err_flag stays 0.
- Reset priming: src_ptr=0110 held through reset, release dest_rst -> dest_vld rises after STAGES+1 cycles; dest_chg never pulses; dest_bin=0100.
- Multi-channel independence: NCH=2, step channel 1 only (0011 -> 0010) -> dest_chg=2'b10; channel 0 outputs unchanged.
- Checker (SYNC_GRAY_CHECK_EN): after dest_vld, jump channel 0 from 0000 -> 0011 -> err_flag[0]=1, err_cnt=1; repeat violations 300 times -> err_cnt saturates at 255.
- Clear collision (SYNC_GRAY_CHECK_EN): err_clr=1 in the same cycle as a new violation -> err_flag[0]=1, err_cnt=1. Then err_clr alone -> err_flag=0, err_cnt=0. Finally, assert dest_rst mid-sweep -> all outputs 0 immediately.
